// File: rtl/status_flag_unit_pkg.sv
`default_nettype none
// ============================================================================
// status_flag_unit_pkg : shared encodings for the NZCV flag producer
// Rev 1.0 - initial release
// ============================================================================
package status_flag_unit_pkg;

    typedef enum logic [1:0] {
        KIND_LOGIC = 2'b00,
        KIND_ADD   = 2'b01,
        KIND_SUB   = 2'b10,
        KIND_MOVE  = 2'b11
    } ex_kind_e;

    localparam int C_FLAG_N = 3;
    localparam int C_FLAG_Z = 2;
    localparam int C_FLAG_C = 1;
    localparam int C_FLAG_V = 0;

    localparam logic [3:0] C_COND_AL = 4'b1110;
    localparam logic [3:0] C_COND_NV = 4'b1111;

    typedef enum logic {
        SAVE_EMPTY = 1'b0,
        SAVE_SAVED = 1'b1
    } save_state_e;

    // AL and NV share their top three bits; neither depends on the flags.
    function automatic logic cond_is_unconditional(input logic [3:0] cond);
        return cond[3:1] == C_COND_AL[3:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_flag_unit_nzcv_gen.sv
`default_nettype none
// ============================================================================
// nzcv_gen : combinational next-state NZCV from the EX-stage ALU outputs
// Rev 1.0 - initial release
// ============================================================================
module nzcv_gen
    import status_flag_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        kind,
    input  logic [DATA_W-1:0] result,
    input  logic              carry,
    input  logic              ovf,
    input  logic              shift_carry,
    input  logic [3:0]        cur_flags,
    output logic [3:0]        next_flags
);

    always_comb begin
        next_flags           = cur_flags;
        next_flags[C_FLAG_N] = result[DATA_W-1];
        next_flags[C_FLAG_Z] = (result == '0);
        if (kind == KIND_ADD || kind == KIND_SUB) begin
            next_flags[C_FLAG_C] = carry;
            next_flags[C_FLAG_V] = ovf;
        end else begin
            // Logic and move keep V; C comes from the shifter.
            next_flags[C_FLAG_C] = shift_carry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/status_flag_unit.sv
`default_nettype none
// ============================================================================
// status_flag_unit : NZCV status register, saved copy and condition hazard
// Optional macro STATUS_FLAG_FWD_EN: bypass next flags to status, no stall.
// Rev 1.0 - initial release
// ============================================================================
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_s,
    input  logic [1:0]        ex_kind,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_carry,
    input  logic              ex_ovf,
    input  logic              ex_shift_carry,
    input  logic              flush,
    input  logic              save_req,
    input  logic              restore_req,
    input  logic              id_valid,
    input  logic [3:0]        id_cond,
    output logic [3:0]        status,
    output logic              hazard_stall,
    output logic              saved_valid,
    output logic              restore_err
);

    logic [3:0]  r_status;
    logic [3:0]  r_saved;
    save_state_e r_state;
    logic        r_restore_err;

    logic        w_we;
    logic        w_restore_ok;
    logic [3:0]  w_gen;
    logic [3:0]  w_next;

    assign w_we         = ex_valid & ex_s & ~flush & ~restore_req;
    assign w_restore_ok = restore_req & (r_state == SAVE_SAVED);

    nzcv_gen #(
        .DATA_W (DATA_W)
    ) u_nzcv_gen (
        .kind        (ex_kind),
        .result      (ex_result),
        .carry       (ex_carry),
        .ovf         (ex_ovf),
        .shift_carry (ex_shift_carry),
        .cur_flags   (r_status),
        .next_flags  (w_gen)
    );

    // An empty-state restore leaves the flags alone (w_we is already low).
    always_comb begin
        w_next = r_status;
        if (w_restore_ok) begin
            w_next = r_saved;
        end else if (w_we) begin
            w_next = w_gen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status      <= 4'b0000;
            r_saved       <= 4'b0000;
            r_state       <= SAVE_EMPTY;
            r_restore_err <= 1'b0;
        end else begin
            r_status      <= w_next;
            r_restore_err <= restore_req & (r_state == SAVE_EMPTY);
            case (r_state)
                SAVE_EMPTY: begin
                    if (save_req && !restore_req) begin
                        r_state <= SAVE_SAVED;
                        r_saved <= w_next;
                    end
                end
                SAVE_SAVED: begin
                    if (restore_req) begin
                        r_state <= SAVE_EMPTY;
                    end else if (save_req) begin
                        r_saved <= w_next;
                    end
                end
                default: r_state <= SAVE_EMPTY;
            endcase
        end
    end

    assign saved_valid = (r_state == SAVE_SAVED);
    assign restore_err = r_restore_err;

`ifdef STATUS_FLAG_FWD_EN
    assign status       = (w_we | restore_req) ? w_next : r_status;
    assign hazard_stall = 1'b0;
`else
    assign status       = r_status;
    assign hazard_stall = id_valid & ~cond_is_unconditional(id_cond) &
                          ex_valid & ex_s & ~flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_status_flag_unit.sv
`default_nettype none
// ============================================================================
// tb_status_flag_unit : randomized self-checking bench against a flag model
// Rev 1.0 - initial release
// ============================================================================
module tb_status_flag_unit;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid, ex_s, ex_carry, ex_ovf, ex_shift_carry;
    logic [1:0]        ex_kind;
    logic [DATA_W-1:0] ex_result;
    logic              flush, save_req, restore_req, id_valid;
    logic [3:0]        id_cond;
    logic [3:0]        status;
    logic              hazard_stall, saved_valid, restore_err;

    int errors = 0;
    int checks = 0;

    // Model state: flags kept as separate named bits.
    bit m_n, m_z, m_c, m_v;
    bit [3:0] m_saved;
    bit       m_has_saved;
    bit       m_err;

    status_flag_unit #(.DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_s           (ex_s),
        .ex_kind        (ex_kind),
        .ex_result      (ex_result),
        .ex_carry       (ex_carry),
        .ex_ovf         (ex_ovf),
        .ex_shift_carry (ex_shift_carry),
        .flush          (flush),
        .save_req       (save_req),
        .restore_req    (restore_req),
        .id_valid       (id_valid),
        .id_cond        (id_cond),
        .status         (status),
        .hazard_stall   (hazard_stall),
        .saved_valid    (saved_valid),
        .restore_err    (restore_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [3:0] m_flags();
        return {m_n, m_z, m_c, m_v};
    endfunction

    // Flags the architectural register should hold after this cycle's edge.
    function automatic bit [3:0] m_next();
        bit write;
        bit n, z, c, v;
        write = ex_valid && ex_s && !flush && !restore_req;
        if (restore_req) return m_has_saved ? m_saved : m_flags();
        if (!write) return m_flags();
        n = ex_result[DATA_W-1];
        z = (ex_result == 0);
        if (ex_kind == 2'd1 || ex_kind == 2'd2) begin
            c = ex_carry; v = ex_ovf;
        end else begin
            c = ex_shift_carry; v = m_v;
        end
        return {n, z, c, v};
    endfunction

    function automatic bit m_stall();
`ifdef STATUS_FLAG_FWD_EN
        return 1'b0;
`else
        return id_valid && !(id_cond == 4'b1110 || id_cond == 4'b1111) &&
               ex_valid && ex_s && !flush;
`endif
    endfunction

    function automatic bit [3:0] m_status_view();
`ifdef STATUS_FLAG_FWD_EN
        if ((ex_valid && ex_s && !flush) || restore_req) return m_next();
`endif
        return m_flags();
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_s = 0; ex_kind = 0; ex_result = 0; ex_carry = 0;
        ex_ovf = 0; ex_shift_carry = 0; flush = 0; save_req = 0;
        restore_req = 0; id_valid = 0; id_cond = 0;
    endtask

    task automatic model_reset();
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_saved = 0; m_has_saved = 0; m_err = 0;
    endtask

    // Called at a falling edge with inputs applied; checks, then advances one edge.
    task automatic step(input string tag);
        bit [3:0] nxt;
        #1;
        chk({tag, ".status"}, {28'd0, status}, {28'd0, m_status_view()});
        chk({tag, ".stall"}, {31'd0, hazard_stall}, {31'd0, m_stall()});
        chk({tag, ".saved_valid"}, {31'd0, saved_valid}, {31'd0, m_has_saved});
        chk({tag, ".restore_err"}, {31'd0, restore_err}, {31'd0, m_err});
        nxt = m_next();
        @(posedge clk);
        m_err = restore_req && !m_has_saved;
        if (save_req && !restore_req) m_saved = nxt;
        if (restore_req) m_has_saved = 0;
        else if (save_req) m_has_saved = 1;
        {m_n, m_z, m_c, m_v} = nxt;
        @(negedge clk);
    endtask

    task automatic ex_op(input logic [1:0] kind, input logic [31:0] res,
                         input logic c, input logic v, input logic sc);
        ex_valid = 1; ex_s = 1; ex_kind = kind; ex_result = res;
        ex_carry = c; ex_ovf = v; ex_shift_carry = sc;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.status", {28'd0, status}, 32'd0);
        chk("reset.saved_valid", {31'd0, saved_valid}, 32'd0);
        chk("reset.restore_err", {31'd0, restore_err}, 32'd0);
        chk("reset.stall", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Subtract to zero with carry: Z and C set.
        ex_op(2'd2, 32'h0, 1'b1, 1'b0, 1'b0);
        step("sub0");
        idle_inputs();
        #1 chk("sub0.const", {28'd0, status}, 32'h6);
        step("idle1");

        // Add with overflow sets V, then a logic op must keep it.
        ex_op(2'd1, 32'h5, 1'b0, 1'b1, 1'b1);
        step("addv");
        ex_op(2'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        step("logic");
        idle_inputs();
        #1 chk("logic.const", {28'd0, status}, 32'h9);
        step("idle2");

        // Hazard with a flag-dependent condition, then AL / NV.
        ex_op(2'd1, 32'h1, 1'b0, 1'b0, 1'b0);
        id_valid = 1; id_cond = 4'b0000;
`ifdef STATUS_FLAG_FWD_EN
        #1 chk("haz.const", {31'd0, hazard_stall}, 32'd0);
`else
        #1 chk("haz.const", {31'd0, hazard_stall}, 32'd1);
`endif
        step("haz_eq");
        idle_inputs();
        step("haz_gone");
        ex_op(2'd1, 32'h1, 1'b0, 1'b0, 1'b0);
        id_valid = 1; id_cond = 4'b1110;
        step("haz_al");
        id_cond = 4'b1111;
        step("haz_nv");
        idle_inputs();

        // Save 0100, overwrite with an add, restore.
        ex_op(2'd2, 32'h0, 1'b0, 1'b0, 1'b0);
        step("set0100");
        idle_inputs(); save_req = 1;
        step("save");
        idle_inputs();
        ex_op(2'd1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        step("add1011");
        idle_inputs(); restore_req = 1;
        step("restore");
        idle_inputs();
        #1 chk("restore.const", {27'd0, saved_valid, status}, 32'h4);
        step("post_restore");

        // Restore while empty, then restore racing an EX write.
        restore_req = 1;
        step("restore_empty");
        idle_inputs();
        #1 chk("rerr.const", {31'd0, restore_err}, 32'd1);
        ex_op(2'd1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1);
        restore_req = 1;
        step("restore_vs_write");
        idle_inputs();
        step("rerr_again");
        step("rerr_clear");

        // Flush with save captures the unchanged flags.
        ex_op(2'd1, 32'h0, 1'b1, 1'b1, 1'b0);
        flush = 1; save_req = 1;
        step("flush_save");
        idle_inputs();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_s           = ($urandom_range(0, 2) != 0);
            ex_kind        = 2'($urandom_range(0, 3));
            ex_result      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            ex_carry       = 1'($urandom);
            ex_ovf         = 1'($urandom);
            ex_shift_carry = 1'($urandom);
            flush          = ($urandom_range(0, 4) == 0);
            save_req       = ($urandom_range(0, 5) == 0);
            restore_req    = ($urandom_range(0, 5) == 0);
            id_valid       = 1'($urandom);
            id_cond        = 4'($urandom_range(0, 15));
            step("rand");
        end

        // Asynchronous reset mid-cycle after a save.
        idle_inputs();
        ex_op(2'd1, 32'h8000_0001, 1'b1, 1'b1, 1'b1);
        save_req = 1;
        step("pre_rst_save");
        idle_inputs();
        @(posedge clk);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("async_rst.status", {28'd0, status}, 32'd0);
        chk("async_rst.saved_valid", {31'd0, saved_valid}, 32'd0);
        chk("async_rst.restore_err", {31'd0, restore_err}, 32'd0);
        chk("async_rst.stall", {31'd0, hazard_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        step("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/status_flag_unit.md
# status_flag_unit

Producer side of the NZCV condition flags. It computes N, Z, C and V from the EX-stage ALU result and holds them in the architectural status register. That register feeds the ID-stage condition check as `status[3:0]`, in the order N, Z, C, V from bit 3 down to bit 0. The unit also keeps a saved copy of the flags for exception entry and return, and it raises a stall when ID evaluates a condition while a flag-setting instruction is still in EX.

## Interface
Parameters:
- `DATA_W`, default 32: ALU result width. N is taken from bit `DATA_W-1`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_s` in 1: the EX instruction sets flags (S bit).
- `ex_kind` in 2: flag class. 00 logic, 01 add/adc, 10 sub/sbc/cmp, 11 move.
- `ex_result` in `DATA_W`: ALU result.
- `ex_carry` in 1: ALU carry out. For subtract this is NOT borrow, per ARM convention.
- `ex_ovf` in 1: ALU signed overflow.
- `ex_shift_carry` in 1: barrel-shifter carry out.
- `flush` in 1: squash the EX instruction, so no flag write happens.
- `save_req` in 1: exception entry; capture the flags into the saved copy.
- `restore_req` in 1: exception return; reload the flags from the saved copy.
- `id_valid` in 1: ID holds a valid instruction.
- `id_cond` in 4: condition field of the ID instruction.
- `status` out 4: NZCV presented to the ID condition check.
- `hazard_stall` out 1: stall IF/ID for one cycle.
- `saved_valid` out 1: the saved copy holds data.
- `restore_err` out 1: one-cycle pulse when a restore is requested with nothing saved.

## Operation
- Write enable: `we = ex_valid & ex_s & ~flush & ~restore_req`.
- Next-flag rules per `ex_kind`:
  - N = `ex_result[DATA_W-1]` and Z = (`ex_result` == 0) for every kind.
  - Logic and move: C = `ex_shift_carry`; V is unchanged.
  - Add and sub: C = `ex_carry`; V = `ex_ovf`.
- State machine for the saved copy:
  - EMPTY → SAVED on `save_req`.
  - SAVED → SAVED on `save_req` (overwrite).
  - SAVED → EMPTY on `restore_req`.
  - EMPTY with `restore_req`: the flags are unchanged and `restore_err` pulses.
- Save value: the saved copy captures the next-state flags. If `we` is high in the same cycle, the newly computed flags are saved.
- Simultaneous events:
  - `restore_req` with an EX write: the restore wins and the write is dropped.
  - `save_req` with `restore_req`: the restore wins and the save is ignored.
  - `flush` with `save_req`: the save captures the unchanged flags.
- Hazard:
  - `hazard_stall = id_valid & (id_cond[3:1] != 3'b111) & ex_valid & ex_s & ~flush`.
  - Conditions 1110 and 1111 never stall.
- Reset values:
  - `status` = 4'b0000, the saved copy = 4'b0000.
  - State = EMPTY, so `saved_valid` = 0.
  - `restore_err` = 0, `hazard_stall` = 0.
- Reset mid-operation clears all state immediately, regardless of any pending save or restore.

## Timing
- `status` is registered. A write in cycle t is visible from cycle t+1.
- `hazard_stall` is combinational from the current-cycle inputs. It lasts exactly one cycle per flag-setting instruction, because the flags are committed on that same edge.
- `saved_valid` is registered and updates on the edge after `save_req` or `restore_req`.
- `restore_err` is registered and high for exactly one cycle.

## Configuration
- `STATUS_FLAG_FWD_EN`:
  - Defined: `status` is a bypass mux. It shows the next-state flags whenever `we` or `restore_req` is high, otherwise the register. `hazard_stall` is tied to 0, and zero-bubble conditional execution follows immediately after an S instruction.
  - Undefined: `status` is the register only, and `hazard_stall` behaves as described under Operation.

## Structure
- Shared package:
  - `ex_kind` encodings.
  - NZCV bit indices (N=3, Z=2, C=1, V=0).
  - Condition codes AL=4'b1110 and NV=4'b1111.
  - Saved-copy state encoding (EMPTY, SAVED).
- One sub-module, `nzcv_gen`: combinational next-flag computation from `ex_kind`, `ex_result`, the carries, `ex_ovf` and the current flags. It is reused by the bypass path.

## Test plan
- Reset, then sub with `ex_result`=0 and `ex_carry`=1, `ex_s`=1 → `status`=4'b0110 the next cycle.
- Logic op with result 32'h8000_0000, `ex_shift_carry`=0, prior V=1 → `status`=4'b1001; V is preserved.
- `ex_s`=1 in EX, `id_cond`=4'b0000, `id_valid`=1 → `hazard_stall`=1 for one cycle (0 if `STATUS_FLAG_FWD_EN` is defined). Repeat with `id_cond`=4'b1110 → `hazard_stall`=0.
- `status`=4'b0100; `save_req`; then an add sets 4'b1011; `restore_req` → `status`=4'b0100 and `saved_valid`=0.
- `restore_req` in state EMPTY → `restore_err` high for one cycle, `status` unchanged. Then `restore_req` together with an EX write → the write is dropped.
- Assert `rst_n`=0 mid-stream after a save → all outputs 0 and `saved_valid`=0 asynchronously.
